seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_if.sv | 23 ++
 rtl/seg_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Control/data bundle for the multiplexed 4-digit 7-segment scanner.
// The master side supplies the digit data and load strobe. The slave side drives the pins.
interface seg_scan_driver_if;
   logic [15:0] value;
   logic [3:0]  blank;
   logic [3:0]  dp_en;
   logic [3:0]  blink;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   modport master (
      output value, blank, dp_en, blink, load,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  value, blank, dp_en, blink, load,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit hex display driver with ghost blanking and per-digit blink.
// New data is double-buffered and applied only at frame boundaries, so a frame never shows mixed data.
module seg_scan_driver #(
   parameter int DIGIT_CYC    = 100000,
   parameter int BLANK_CYC    = 1000,
   parameter int BLINK_FRAMES = 128
) (
   input logic              clk,
   input logic              rst,
   seg_scan_driver_if.slave io_bus
);

   localparam int CNT_W = (DIGIT_CYC > 2) ? $clog2(DIGIT_CYC) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_digit;
   logic [0:0]       r_state;
   logic [FRM_W-1:0] r_fcnt;
   logic             r_phase;

   logic             r_pend_vld;
   logic [15:0]      r_pend_val;
   logic [3:0]       r_pend_blank;
   logic [3:0]       r_pend_dp;
   logic [3:0]       r_pend_blink;

   logic [15:0]      r_act_val;
   logic [3:0]       r_act_blank;
   logic [3:0]       r_act_dp;
   logic [3:0]       r_act_blink;

   logic [6:0]       r_seg;
   logic             r_dp;
   logic [3:0]       r_an;
   logic             r_frame_done;

   logic             w_bnd;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       w_nibble;
   logic             w_dark;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      w_bnd     = (r_digit == 2'd3) && (r_cnt == CNT_LAST);
      w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      case (r_digit)
         2'd0:    w_nibble = r_act_val[3:0];
         2'd1:    w_nibble = r_act_val[7:4];
         2'd2:    w_nibble = r_act_val[11:8];
         default: w_nibble = r_act_val[15:12];
      endcase
      w_dark = r_act_blank[r_digit] | (r_act_blink[r_digit] & r_phase);
   end

   // State follows the next count, so BLANK/DRIVE always matches the counter value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_digit <= 2'd0;
         r_state <= ST_BLANK;
      end else begin
         r_cnt   <= w_cnt_nxt;
         if (r_cnt == CNT_LAST)
            r_digit <= r_digit + 1'b1;
         r_state <= (w_cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fcnt  <= '0;
         r_phase <= 1'b0;
      end else if (w_bnd) begin
         if (r_fcnt == FRM_LAST) begin
            r_fcnt  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   // Pending data needs no reset: it is only consumed while r_pend_vld is set.
   always_ff @(posedge clk) begin
      if (io_bus.load && !w_bnd) begin
         r_pend_val   <= io_bus.value;
         r_pend_blank <= io_bus.blank;
         r_pend_dp    <= io_bus.dp_en;
         r_pend_blink <= io_bus.blink;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_vld  <= 1'b0;
         r_act_val   <= 16'h0000;
         r_act_blank <= 4'b1111;
         r_act_dp    <= 4'b0000;
         r_act_blink <= 4'b0000;
      end else if (w_bnd) begin
         r_pend_vld <= 1'b0;
         if (io_bus.load) begin
            r_act_val   <= io_bus.value;
            r_act_blank <= io_bus.blank;
            r_act_dp    <= io_bus.dp_en;
            r_act_blink <= io_bus.blink;
         end else if (r_pend_vld) begin
            r_act_val   <= r_pend_val;
            r_act_blank <= r_pend_blank;
            r_act_dp    <= r_pend_dp;
            r_act_blink <= r_pend_blink;
         end
      end else if (io_bus.load) begin
         r_pend_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_an         <= 4'b1111;
         r_seg        <= 7'b1111111;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_bnd;
         if (r_state == ST_DRIVE && !w_dark) begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= hex7(w_nibble);
            r_dp  <= ~r_act_dp[r_digit];
         end else begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
         end
      end
   end

   assign io_bus.an         = r_an;
   assign io_bus.seg        = r_seg;
   assign io_bus.dp         = r_dp;
   assign io_bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: per-slot expectations are queued per frame and popped at each negedge.
// Expected outputs are built from the display data, the slot position and the blink phase.
module tb_seg_scan_driver;
   localparam int DC = 8;
   localparam int BC = 2;
   localparam int BF = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg_scan_driver_if bus ();

   seg_scan_driver #(.DIGIT_CYC(DC), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int nbnd   = 0;
   logic [12:0] sbq [$];
   logic [12:0] got, exp_v;
   logic [15:0] a_val;
   logic [3:0]  a_bl, a_dp, a_bk;
   logic [6:0]  HEX [0:15];

   // Packed as {an, seg, dp, frame_done}.
   function automatic logic [12:0] exp_slot(input logic [15:0] v, input logic [3:0] bl,
                                            input logic [3:0] dpe, input logic [3:0] bk,
                                            input logic ph, input int j);
      int d, c;
      logic [15:0] sh;
      logic [3:0]  an_e;
      logic        fd;
      d  = (j / DC) % 4;
      c  = j % DC;
      fd = ((j % (4 * DC)) == (4 * DC - 1));
      if (c < BC || bl[d] || (bk[d] && ph))
         return {4'hF, 7'h7F, 1'b1, fd};
      sh = v >> (4 * d);
      an_e = 4'hF;
      an_e[d] = 1'b0;
      return {an_e, HEX[sh[3:0]], ~dpe[d], fd};
   endfunction

   function automatic logic phase_of(input int n);
      return ((n / BF) % 2) == 1;
   endfunction

   task automatic push_frame(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] dpe,
                             input logic [3:0] bk, input logic ph);
      for (int j = 0; j < 4 * DC; j++)
         sbq.push_back(exp_slot(v, bl, dpe, bk, ph, j));
   endtask

   task automatic drive_load(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] dpe,
                             input logic [3:0] bk);
      bus.value = v;
      bus.blank = bl;
      bus.dp_en = dpe;
      bus.blink = bk;
      bus.load  = 1'b1;
   endtask

   task automatic set_active(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] dpe,
                             input logic [3:0] bk);
      a_val = v; a_bl = bl; a_dp = dpe; a_bk = bk;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_load(16'h0, 4'h0, 4'h0, 4'h0);
      bus.load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         checks++;
         if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, got, {4'hF, 7'h7F, 1'b1, 1'b0});
         end
      end
      rst = 1'b0;
      nbnd = 0;
      set_active(16'h0, 4'hF, 4'h0, 4'h0);
      for (int f = 0; f < 3; f++) push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd + f));
      for (int j = 0; j < 3 * 4 * DC; j++) begin
         @(negedge clk);
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         exp_v = sbq.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL dark_after_reset j=%0d got=%h exp=%h", j, got, exp_v);
         end
         if (j % (4 * DC) == 4 * DC - 1) nbnd++;
      end
   endtask

   task automatic test_load();
      push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd));
      drive_load(16'h1234, 4'h0, 4'b0001, 4'h0);
      set_active(16'h1234, 4'h0, 4'b0001, 4'h0);
      push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd + 1));
      for (int j = 0; j < 2 * 4 * DC; j++) begin
         @(negedge clk);
         if (j == 0) bus.load = 1'b0;
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         exp_v = sbq.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL load_1234 j=%0d got=%h exp=%h", j, got, exp_v);
         end
         if (j % (4 * DC) == 4 * DC - 1) nbnd++;
      end
   endtask

   task automatic test_last_wins();
      push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd));
      drive_load(16'hAAAA, 4'h0, 4'h0, 4'h0);
      set_active(16'h5555, 4'h0, 4'h0, 4'h0);
      push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd + 1));
      for (int j = 0; j < 2 * 4 * DC; j++) begin
         @(negedge clk);
         if (j == 0 || j == 11) bus.load = 1'b0;
         if (j == 10) drive_load(16'h5555, 4'h0, 4'h0, 4'h0);
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         exp_v = sbq.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL last_load_wins j=%0d got=%h exp=%h", j, got, exp_v);
         end
         if (j % (4 * DC) == 4 * DC - 1) nbnd++;
      end
   endtask

   task automatic test_boundary_load();
      push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd));
      set_active(16'h8888, 4'h0, 4'b1010, 4'h0);
      push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd + 1));
      for (int j = 0; j < 2 * 4 * DC; j++) begin
         @(negedge clk);
         if (j == 4 * DC - 2) drive_load(16'h8888, 4'h0, 4'b1010, 4'h0);
         if (j == 4 * DC - 1) bus.load = 1'b0;
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         exp_v = sbq.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL boundary_load j=%0d got=%h exp=%h", j, got, exp_v);
         end
         if (j % (4 * DC) == 4 * DC - 1) nbnd++;
      end
   endtask

   task automatic test_blink();
      push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd));
      drive_load(16'hBD6E, 4'h0, 4'h0, 4'b0100);
      set_active(16'hBD6E, 4'h0, 4'h0, 4'b0100);
      for (int f = 1; f <= 4; f++) push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd + f));
      for (int j = 0; j < 5 * 4 * DC; j++) begin
         @(negedge clk);
         if (j == 0) bus.load = 1'b0;
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         exp_v = sbq.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL blink_digit2 j=%0d got=%h exp=%h", j, got, exp_v);
         end
         if (j % (4 * DC) == 4 * DC - 1) nbnd++;
      end
   endtask

   task automatic test_reset_mid();
      for (int j = 0; j <= 2 * DC + 4; j++)
         sbq.push_back(exp_slot(a_val, a_bl, a_dp, a_bk, phase_of(nbnd), j));
      drive_load(16'h4321, 4'h0, 4'hF, 4'h0);
      for (int j = 0; j <= 2 * DC + 4; j++) begin
         @(negedge clk);
         if (j == 0) bus.load = 1'b0;
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         exp_v = sbq.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_drive j=%0d got=%h exp=%h", j, got, exp_v);
         end
      end
      rst = 1'b1;
      drive_load(16'h9999, 4'h0, 4'hF, 4'h0);
      @(negedge clk);
      got = {bus.an, bus.seg, bus.dp, bus.frame_done};
      checks++;
      if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midslot_reset got=%h exp=%h", got, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      @(negedge clk);
      rst = 1'b0;
      bus.load = 1'b0;
      nbnd = 0;
      set_active(16'h0, 4'hF, 4'h0, 4'h0);
      for (int f = 0; f < 2; f++) push_frame(a_val, a_bl, a_dp, a_bk, phase_of(nbnd + f));
      for (int j = 0; j < 2 * 4 * DC; j++) begin
         @(negedge clk);
         got = {bus.an, bus.seg, bus.dp, bus.frame_done};
         exp_v = sbq.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL pending_discarded j=%0d got=%h exp=%h", j, got, exp_v);
         end
         if (j % (4 * DC) == 4 * DC - 1) nbnd++;
      end
   endtask

   initial begin
      HEX = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      test_reset();
      test_load();
      test_last_wins();
      test_boundary_load();
      test_blink();
      test_reset_mid();
      checks++;
      if (sbq.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
